// File: rtl/atm_dispenser.sv
// rtl/atm_dispenser.sv - cash dispenser: note planning, paced eject pulses, cassette stock
module atm_dispenser #(
    parameter int STOCK_W     = 6,
    parameter int INIT_STOCK  = 20,
    parameter int NOTE_CYCLES = 4
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Request,
    input  logic [4:0]         Amount,
    input  logic               Load,
    input  logic [1:0]         LoadSel,
    input  logic [STOCK_W-1:0] LoadCount,
    input  logic [1:0]         StockSel,
    output logic [STOCK_W-1:0] StockOut,
    output logic               Busy,
    output logic               NoteValid,
    output logic [1:0]         NoteSel,
    output logic               Done,
    output logic               ErrStock
);
    localparam int GAP_W = $clog2(NOTE_CYCLES);
    localparam int CMP_W = (STOCK_W > 5) ? STOCK_W : 5;
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(NOTE_CYCLES - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);

    typedef enum logic [2:0] {IDLE, PLAN, CHECK, DISPENSE, FINISH, ERROR} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         rem;
    logic [4:0]         cnt [4];
    logic [1:0]         plan_idx;     // cassette being planned; walks 3 (tens) down to 0 (ones)
    logic [GAP_W-1:0]   gap;          // position within one note slot; a note goes out at 0
    logic [STOCK_W-1:0] stock [4];

    logic [4:0]         plan_den;
    logic [4:0]         plan_quo;
    logic [4:0]         plan_take;
    logic [4:0]         plan_rem;
    logic [CMP_W-1:0]   plan_quo_ext;
    logic [CMP_W-1:0]   plan_stock_ext;
    logic [1:0]         note_idx;
    logic               notes_left;
    logic [STOCK_W:0]   load_sum;
    logic [STOCK_W-1:0] load_sat;

    assign StockOut = stock[StockSel];

    // Refill adds with saturation at the counter's full scale.
    assign load_sum = {1'b0, stock[LoadSel]} + {1'b0, LoadCount};
    assign load_sat = load_sum[STOCK_W] ? {STOCK_W{1'b1}} : load_sum[STOCK_W-1:0];

    // Greedy step for the current denomination: take as many notes as fit, limited by stock.
    always_comb begin
        case (plan_idx)
            2'd3:    plan_den = 5'd10;
            2'd2:    plan_den = 5'd5;
            2'd1:    plan_den = 5'd2;
            default: plan_den = 5'd1;
        endcase
        plan_quo       = rem / plan_den;
        plan_quo_ext   = CMP_W'(plan_quo);
        plan_stock_ext = CMP_W'(stock[plan_idx]);
        plan_take      = (plan_stock_ext < plan_quo_ext) ? 5'(plan_stock_ext) : plan_quo;
        // take*den never exceeds rem, so the 5-bit product is exact
        plan_rem       = rem - plan_take * plan_den;
    end

    // Largest denomination with notes still owed is the next one ejected.
    always_comb begin
        if (cnt[3] != 5'd0)      note_idx = 2'd3;
        else if (cnt[2] != 5'd0) note_idx = 2'd2;
        else if (cnt[1] != 5'd0) note_idx = 2'd1;
        else                     note_idx = 2'd0;
        notes_left = (cnt[0] | cnt[1] | cnt[2] | cnt[3]) != 5'd0;
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and outputs.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        NoteValid = 1'b0;
        NoteSel   = 2'd0;
        Done      = 1'b0;
        ErrStock  = 1'b0;
        case (state)
            IDLE: begin
                if (Request) state_nxt = PLAN;
            end
            PLAN: begin
                Busy = 1'b1;
                if (plan_idx == 2'd0) state_nxt = CHECK;
            end
            CHECK: begin
                Busy = 1'b1;
                if (rem != 5'd0)     state_nxt = ERROR;
                else if (!notes_left) state_nxt = FINISH;
                else                  state_nxt = DISPENSE;
            end
            DISPENSE: begin
                Busy      = 1'b1;
                NoteValid = (gap == '0) && notes_left;
                NoteSel   = NoteValid ? note_idx : 2'd0;
                // counts are already drained by the last slot's final cycle
                if (gap == GAP_LAST && !notes_left) state_nxt = FINISH;
            end
            FINISH: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            ERROR: begin
                Busy      = 1'b1;
                ErrStock  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: refills and capture in IDLE, planning, note pacing and stock decrement.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            rem      <= 5'd0;
            plan_idx <= 2'd0;
            gap      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= 5'd0;
                stock[i] <= STOCK_RST;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (Load) stock[LoadSel] <= load_sat;
                    if (Request) begin
                        rem      <= Amount;
                        plan_idx <= 2'd3;
                        for (int i = 0; i < 4; i++) cnt[i] <= 5'd0;
                    end
                end
                PLAN: begin
                    cnt[plan_idx] <= plan_take;
                    rem           <= plan_rem;
                    plan_idx      <= plan_idx - 2'd1;
                end
                CHECK: gap <= '0;
                DISPENSE: begin
                    gap <= (gap == GAP_LAST) ? '0 : gap + GAP_W'(1);
                    if (NoteValid) begin
                        cnt[note_idx]   <= cnt[note_idx] - 5'd1;
                        stock[note_idx] <= stock[note_idx] - STOCK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_dispenser.sv
// tb/tb_atm_dispenser.sv - directed table-driven bench for atm_dispenser
module tb_atm_dispenser;
    localparam int NC = 4;

    logic       Clock = 1'b0;
    logic       Clear = 1'b1;
    logic       Request = 1'b0;
    logic [4:0] Amount = 5'd0;
    logic       Load = 1'b0;
    logic [1:0] LoadSel = 2'd0;
    logic [5:0] LoadCount = 6'd0;
    logic [1:0] StockSel = 2'd0;
    logic       which = 1'b0;

    logic [5:0] so0, so1;
    logic       busy0, nv0, done0, err0;
    logic       busy1, nv1, done1, err1;
    logic [1:0] sel0, sel1;

    logic [5:0] o_so;
    logic       o_busy, o_nv, o_done, o_err;
    logic [1:0] o_sel;

    int checks = 0;
    int errors = 0;

    atm_dispenser #(.STOCK_W(6), .INIT_STOCK(20), .NOTE_CYCLES(NC)) dut (
        .Clock(Clock), .Clear(Clear), .Request(Request), .Amount(Amount),
        .Load(Load), .LoadSel(LoadSel), .LoadCount(LoadCount), .StockSel(StockSel),
        .StockOut(so0), .Busy(busy0), .NoteValid(nv0), .NoteSel(sel0),
        .Done(done0), .ErrStock(err0)
    );

    atm_dispenser #(.STOCK_W(6), .INIT_STOCK(1), .NOTE_CYCLES(NC)) dut1 (
        .Clock(Clock), .Clear(Clear), .Request(Request), .Amount(Amount),
        .Load(Load), .LoadSel(LoadSel), .LoadCount(LoadCount), .StockSel(StockSel),
        .StockOut(so1), .Busy(busy1), .NoteValid(nv1), .NoteSel(sel1),
        .Done(done1), .ErrStock(err1)
    );

    assign o_so   = which ? so1   : so0;
    assign o_busy = which ? busy1 : busy0;
    assign o_nv   = which ? nv1   : nv0;
    assign o_sel  = which ? sel1  : sel0;
    assign o_done = which ? done1 : done0;
    assign o_err  = which ? err1  : err0;

    always #5 Clock = ~Clock;

    typedef struct {
        bit         which;   // 0: INIT_STOCK=20 instance, 1: INIT_STOCK=1 instance
        bit         clr;
        logic [4:0] amount;
        bit         ld;
        logic [1:0] lsel;
        logic [5:0] lcnt;
        int         inj;     // cycle offset of an ignored Request+Load pulse, 0 = none
        int         n;
        logic [7:0] sels;    // note i denomination in bits [2i+1:2i]
        int         end_at;  // cycle offset of Done or ErrStock
        bit         err;
        logic [23:0] stk;    // {s10, s5, s2, s1} after the transaction
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mkv(bit w, bit c, logic [4:0] a, bit l, logic [1:0] ls,
                                 logic [5:0] lc, int inj, int n, logic [7:0] sels,
                                 int e, bit er, logic [5:0] s3, logic [5:0] s2,
                                 logic [5:0] s1, logic [5:0] s0);
        vec_t v;
        v.which = w;  v.clr = c;   v.amount = a; v.ld = l; v.lsel = ls; v.lcnt = lc;
        v.inj = inj;  v.n = n;     v.sels = sels; v.end_at = e; v.err = er;
        v.stk = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         nidx;
        bit         exp_nv;
        logic [7:0] tmp;
        which = v.which;
        if (v.clr) begin
            Clear = 1'b1;
            repeat (2) @(negedge Clock);
            Clear = 1'b0;
        end
        Amount = v.amount; Request = 1'b1;
        Load = v.ld; LoadSel = v.lsel; LoadCount = v.lcnt;
        for (int j = 1; j <= v.end_at + 2; j++) begin
            @(negedge Clock);
            nidx   = (j >= 6) ? (j - 6) / NC : 0;
            exp_nv = !v.err && (j >= 6) && ((j - 6) % NC == 0) && (nidx < v.n);
            chk($sformatf("v%0d c%0d NoteValid", idx, j), int'(o_nv), int'(exp_nv));
            if (exp_nv) begin
                tmp = v.sels >> (2 * nidx);
                chk($sformatf("v%0d c%0d NoteSel", idx, j), int'(o_sel), int'(tmp[1:0]));
            end
            chk($sformatf("v%0d c%0d Done", idx, j), int'(o_done), int'(!v.err && j == v.end_at));
            chk($sformatf("v%0d c%0d ErrStock", idx, j), int'(o_err), int'(v.err && j == v.end_at));
            chk($sformatf("v%0d c%0d Busy", idx, j), int'(o_busy), int'(j <= v.end_at));
            Request = 1'b0;
            Load    = 1'b0;
            if (j == v.inj) begin
                Request = 1'b1; Load = 1'b1; LoadSel = 2'd3; LoadCount = 6'd5; Amount = 5'd1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            StockSel = 2'(s);
            #1;
            chk($sformatf("v%0d stock[%0d]", idx, s), int'(o_so), int'(v.stk[s*6 +: 6]));
        end
    endtask

    initial begin
        int nv_seen, done_seen, busy_seen;

        vecs[0] = mkv(1, 1, 5'd31, 0, 2'd0, 6'd0, 0, 0, 8'h00,  6, 1, 6'd1,  6'd1,  6'd1,  6'd1);
        vecs[1] = mkv(1, 0, 5'd14, 1, 2'd1, 6'd3, 0, 3, 8'h17, 18, 0, 6'd0,  6'd1,  6'd2,  6'd1);
        vecs[2] = mkv(1, 0, 5'd3,  0, 2'd0, 6'd0, 0, 2, 8'h01, 14, 0, 6'd0,  6'd1,  6'd1,  6'd0);
        vecs[3] = mkv(0, 1, 5'd18, 0, 2'd0, 6'd0, 0, 4, 8'h1B, 22, 0, 6'd19, 6'd19, 6'd19, 6'd19);
        vecs[4] = mkv(0, 1, 5'd0,  0, 2'd0, 6'd0, 0, 0, 8'h00,  6, 0, 6'd20, 6'd20, 6'd20, 6'd20);
        vecs[5] = mkv(0, 1, 5'd25, 0, 2'd0, 6'd0, 8, 3, 8'h2F, 18, 0, 6'd18, 6'd19, 6'd20, 6'd20);
        vecs[6] = mkv(0, 1, 5'd31, 0, 2'd0, 6'd0, 0, 4, 8'h3F, 22, 0, 6'd17, 6'd20, 6'd20, 6'd19);
        vecs[7] = mkv(0, 1, 5'd9,  0, 2'd0, 6'd0, 0, 3, 8'h16, 18, 0, 6'd20, 6'd19, 6'd18, 6'd20);
        vecs[8] = mkv(0, 1, 5'd1,  0, 2'd0, 6'd0, 0, 1, 8'h00, 10, 0, 6'd20, 6'd20, 6'd20, 6'd19);

        // reset state
        Clear = 1'b1;
        repeat (2) @(negedge Clock);
        chk("reset Busy", int'(busy0), 0);
        chk("reset NoteValid", int'(nv0), 0);
        chk("reset NoteSel", int'(sel0), 0);
        chk("reset Done", int'(done0), 0);
        chk("reset ErrStock", int'(err0), 0);
        for (int s = 0; s < 4; s++) begin
            StockSel = 2'(s);
            #1;
            chk($sformatf("reset stock[%0d]", s), int'(so0), 20);
            chk($sformatf("reset dut1 stock[%0d]", s), int'(so1), 1);
        end
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // refill saturation while idle
        which = 1'b0;
        Clear = 1'b1;
        repeat (2) @(negedge Clock);
        Clear = 1'b0;
        Load = 1'b1; LoadSel = 2'd3; LoadCount = 6'd63;
        @(negedge Clock);
        LoadSel = 2'd0; LoadCount = 6'd5;
        @(negedge Clock);
        Load = 1'b0;
        StockSel = 2'd3; #1;
        chk("refill saturate stock[3]", int'(so0), 63);
        StockSel = 2'd0; #1;
        chk("refill add stock[0]", int'(so0), 25);
        @(negedge Clock);

        // Clear in the middle of a 4-note dispense
        Clear = 1'b1;
        repeat (2) @(negedge Clock);
        Clear = 1'b0;
        Amount = 5'd18; Request = 1'b1; StockSel = 2'd3;
        nv_seen = 0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge Clock);
            Request = 1'b0;
            if (nv0) nv_seen++;
        end
        chk("abort notes before Clear", nv_seen, 2);
        chk("abort stock[3] before Clear", int'(so0), 19);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        nv_seen = 0; done_seen = 0; busy_seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge Clock);
            if (nv0)   nv_seen++;
            if (done0) done_seen++;
            if (busy0) busy_seen++;
        end
        chk("abort NoteValid after Clear", nv_seen, 0);
        chk("abort Done after Clear", done_seen, 0);
        chk("abort Busy after Clear", busy_seen, 0);
        for (int s = 0; s < 4; s++) begin
            StockSel = 2'(s);
            #1;
            chk($sformatf("abort stock[%0d]", s), int'(so0), 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
